// File: rtl/prbs7_checker_if.sv
// -----------------------------------------------------------------------------
// prbs7_checker_if
// Bundles the serial receive stream and the checker status outputs.
//   en        : bit_in valid this cycle
//   bit_in    : received serial bit
//   clr_count : synchronous clear of err_count
//   locked    : high while the checker is locked to the stream
//   err_pulse : one-cycle pulse after a mismatch while locked
//   err_count : saturating count of mismatches while locked
// Modports: master drives the stream (link/bench side), slave is the checker.
// CNT_WIDTH must match the CNT_WIDTH of the connected checker.
// -----------------------------------------------------------------------------
interface prbs7_checker_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 en;
  logic                 bit_in;
  logic                 clr_count;
  logic                 locked;
  logic                 err_pulse;
  logic [CNT_WIDTH-1:0] err_count;

  modport master (
    output en, bit_in, clr_count,
    input  locked, err_pulse, err_count
  );

  modport slave (
    input  en, bit_in, clr_count,
    output locked, err_pulse, err_count
  );
endinterface

// File: rtl/prbs7_checker.sv
// -----------------------------------------------------------------------------
// prbs7_checker
// Serial PRBS7 (x^7 + x^3 + 1) receive checker. Loads 7 received bits into a
// history register, then predicts every following bit as h[7]^h[3]. After
// LOCK_COUNT consecutive good predictions it declares lock, then counts
// mismatches and drops lock after UNLOCK_ERRS consecutive mismatches.
//
// Ports:
//   clk  : clock, all logic on rising edge
//   rst  : synchronous active-high reset
//   bus  : prbs7_checker_if.slave (en, bit_in, clr_count in;
//          locked, err_pulse, err_count out, all registered)
//
// Optional build macro PRBS7_CHK_FREERUN_EN: when defined, the history
// register free-runs on its own prediction while locked, so one channel bit
// error gives exactly one mismatch. When undefined the received bit is always
// shifted in (self-synchronous) and one bit error shows up three times.
// -----------------------------------------------------------------------------
module prbs7_checker #(
  parameter int LOCK_COUNT  = 14,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic            clk,
  input  logic            rst,
  prbs7_checker_if.slave  bus
);

  localparam int RUN_W  = (LOCK_COUNT  < 1) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = (UNLOCK_ERRS < 1) ? 1 : $clog2(UNLOCK_ERRS + 1);

  typedef enum logic [1:0] {
    ST_SEED    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  // Next PRBS7 bit predicted from the last seven bits (h[1] newest).
  function automatic logic prbs7_predict(input logic [7:1] hist);
    return hist[7] ^ hist[3];
  endfunction

  state_e               state_q,     state_d;
  logic [7:1]           h_q,         h_d;
  logic [2:0]           seed_cnt_q,  seed_cnt_d;
  logic [RUN_W-1:0]     run_cnt_q,   run_cnt_d;
  logic [MISS_W-1:0]    miss_cnt_q,  miss_cnt_d;
  logic                 locked_q,    locked_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [CNT_WIDTH-1:0] err_count_q, err_count_d;

  logic                 expected_s;
  logic                 mismatch_s;
  logic                 lock_shift_s;
  logic [RUN_W-1:0]     run_inc_s;
  logic [MISS_W-1:0]    miss_inc_s;

  // Next-state computation for the FSM, history and counters.
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    seed_cnt_d  = seed_cnt_q;
    run_cnt_d   = run_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;

    expected_s  = prbs7_predict(h_q);
    mismatch_s  = bus.bit_in ^ expected_s;
    run_inc_s   = run_cnt_q + RUN_W'(1);
    miss_inc_s  = miss_cnt_q + MISS_W'(1);

`ifdef PRBS7_CHK_FREERUN_EN
    lock_shift_s = expected_s;
`else
    lock_shift_s = bus.bit_in;
`endif

    if (bus.en) begin
      case (state_q)
        ST_SEED: begin
          h_d = {h_q[6:1], bus.bit_in};
          if (seed_cnt_q == 3'd6) begin
            state_d    = ST_ACQUIRE;
            seed_cnt_d = 3'd0;
            run_cnt_d  = '0;
          end else begin
            seed_cnt_d = seed_cnt_q + 3'd1;
          end
        end

        ST_ACQUIRE: begin
          h_d = {h_q[6:1], bus.bit_in};
          // An all-zero history predicts 0 forever; never let it count.
          if (!mismatch_s && (h_q != 7'd0)) begin
            if (run_inc_s == RUN_W'(LOCK_COUNT)) begin
              state_d    = ST_LOCKED;
              run_cnt_d  = '0;
              miss_cnt_d = '0;
            end else begin
              run_cnt_d = run_inc_s;
            end
          end else begin
            run_cnt_d = '0;
          end
        end

        ST_LOCKED: begin
          h_d = {h_q[6:1], lock_shift_s};
          if (mismatch_s) begin
            err_pulse_d = 1'b1;
            if (err_count_q != {CNT_WIDTH{1'b1}}) begin
              err_count_d = err_count_q + CNT_WIDTH'(1);
            end else begin
              err_count_d = err_count_q;
            end
            // The unlocking mismatch is still pulsed and counted above.
            if (miss_inc_s == MISS_W'(UNLOCK_ERRS)) begin
              state_d    = ST_SEED;
              h_d        = 7'd0;
              seed_cnt_d = 3'd0;
              run_cnt_d  = '0;
              miss_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_inc_s;
            end
          end else begin
            miss_cnt_d = '0;
          end
        end

        default: begin
          state_d    = ST_SEED;
          h_d        = 7'd0;
          seed_cnt_d = 3'd0;
          run_cnt_d  = '0;
          miss_cnt_d = '0;
        end
      endcase
    end else begin
      err_pulse_d = 1'b0;
    end

    // Clear beats a simultaneous increment; the pulse is unaffected.
    if (bus.clr_count) begin
      err_count_d = '0;
    end else begin
      err_count_d = err_count_d;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SEED;
      h_q         <= 7'd0;
      seed_cnt_q  <= 3'd0;
      run_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      seed_cnt_q  <= seed_cnt_d;
      run_cnt_q   <= run_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs7_checker
// Two checkers share one stimulus stream: ch0 uses the default parameters,
// ch1 uses CNT_WIDTH=4 / UNLOCK_ERRS=32 so saturation can be reached. Every
// cycle both are compared against a reference model that keeps the full list
// of shifted bits in an array and predicts from bit n-7 and n-3. A constant
// table covers the lock-from-reset sequence; hand-written sequences cover
// bit errors, inverted streams, stuck-0, random enable, saturation and reset.
// -----------------------------------------------------------------------------
module tb_prbs7_checker;

  localparam int LOCK_COUNT = 14;

  logic clk;
  logic rst;

  prbs7_checker_if #(.CNT_WIDTH(16)) if0 ();
  prbs7_checker_if #(.CNT_WIDTH(4))  if1 ();

  prbs7_checker #(.LOCK_COUNT(LOCK_COUNT), .UNLOCK_ERRS(4), .CNT_WIDTH(16)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  prbs7_checker #(.LOCK_COUNT(LOCK_COUNT), .UNLOCK_ERRS(32), .CNT_WIDTH(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  int m_mode   [2];   // 0 seed, 1 acquire, 2 locked
  int m_n      [2];   // number of bits in history since last resync
  int m_run    [2];
  int m_miss   [2];
  int m_cnt    [2];
  bit m_locked [2];
  bit m_pulse  [2];
  bit hb [2][4096];
  int m_unl  [2] = '{4, 32};
  int m_cmax [2] = '{65535, 15};

  function automatic bit hget(int c, int idx);
    if (idx < 0) return 1'b0;
    return hb[c][idx & 4095];
  endfunction

  task automatic hpush(int c, bit v);
    hb[c][m_n[c] & 4095] = v;
    m_n[c]++;
  endtask

  task automatic model_step(int c, bit r, bit e, bit b, bit cl);
    bit exp_b, mism, nz, inc;
    if (r) begin
      m_mode[c] = 0; m_n[c] = 0; m_run[c] = 0; m_miss[c] = 0;
      m_cnt[c] = 0; m_locked[c] = 1'b0; m_pulse[c] = 1'b0;
      return;
    end
    m_pulse[c] = 1'b0;
    inc = 1'b0;
    if (e) begin
      exp_b = hget(c, m_n[c] - 7) ^ hget(c, m_n[c] - 3);
      mism  = (b != exp_b);
      nz    = 1'b0;
      for (int k = 1; k <= 7; k++) nz |= hget(c, m_n[c] - k);
      if (m_mode[c] == 0) begin
        hpush(c, b);
        if (m_n[c] == 7) begin m_mode[c] = 1; m_run[c] = 0; end
      end else if (m_mode[c] == 1) begin
        hpush(c, b);
        if (!mism && nz) begin
          m_run[c]++;
          if (m_run[c] == LOCK_COUNT) begin m_mode[c] = 2; m_miss[c] = 0; end
        end else begin
          m_run[c] = 0;
        end
      end else begin
`ifdef PRBS7_CHK_FREERUN_EN
        hpush(c, exp_b);
`else
        hpush(c, b);
`endif
        if (mism) begin
          m_pulse[c] = 1'b1;
          inc = 1'b1;
          m_miss[c]++;
          if (m_miss[c] == m_unl[c]) begin
            m_mode[c] = 0; m_n[c] = 0; m_run[c] = 0; m_miss[c] = 0;
          end
        end else begin
          m_miss[c] = 0;
        end
      end
    end
    if (cl) m_cnt[c] = 0;
    else if (inc && m_cnt[c] < m_cmax[c]) m_cnt[c]++;
    m_locked[c] = (m_mode[c] == 2);
  endtask

  // ---------------- stream generator (seed 7'b0000001) ----------------
  bit [7:1] gs;
  function automatic bit gen_next();
    bit nb;
    nb = gs[7] ^ gs[3];
    gs = {gs[6:1], nb};
    return nb;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance model, compare both channels.
  task automatic step(input bit r, input bit e, input bit b, input bit cl);
    rst = r;
    if0.en = e; if0.bit_in = b; if0.clr_count = cl;
    if1.en = e; if1.bit_in = b; if1.clr_count = cl;
    @(posedge clk);
    #1;
    model_step(0, r, e, b, cl);
    model_step(1, r, e, b, cl);
    check("ch0_locked", {31'd0, if0.locked},    {31'd0, m_locked[0]});
    check("ch0_pulse",  {31'd0, if0.err_pulse}, {31'd0, m_pulse[0]});
    check("ch0_count",  {16'd0, if0.err_count}, m_cnt[0]);
    check("ch1_locked", {31'd0, if1.locked},    {31'd0, m_locked[1]});
    check("ch1_pulse",  {31'd0, if1.err_pulse}, {31'd0, m_pulse[1]});
    check("ch1_count",  {28'd0, if1.err_count}, m_cnt[1]);
  endtask

  typedef struct {
    bit r; bit e; bit b; bit cl;
    bit el; bit ep; int ec;
  } vec_t;

  vec_t tbl [29];

`ifdef PRBS7_CHK_FREERUN_EN
  localparam int ISO_CNT = 1;
  localparam int UNL_BIT = 4;    // inverted bits until ch0 unlocks
  localparam int UNL_CNT = 4;
`else
  localparam int ISO_CNT = 3;    // mismatches at offsets 0, +3, +7
  // Inverted bits 4..7 have one inverted tap and predict correctly, so
  // four consecutive mismatches first occur at inverted bits 8..11.
  localparam int UNL_BIT = 11;
  localparam int UNL_CNT = 7;
`endif

  initial begin : main
    bit b;
    int en_cnt;
    int lock_at;

    rst = 1'b1;
    if0.en = 1'b0; if0.bit_in = 1'b0; if0.clr_count = 1'b0;
    if1.en = 1'b0; if1.bit_in = 1'b0; if1.clr_count = 1'b0;

    // ---- table: reset, clean lock after 21 bits, en=0 hold, more clean bits
    gs = 7'b0000001;
    tbl[0] = '{r:1'b1, e:1'b0, b:1'b0, cl:1'b0, el:1'b0, ep:1'b0, ec:0};
    for (int i = 1; i <= 21; i++)
      tbl[i] = '{r:1'b0, e:1'b1, b:gen_next(), cl:1'b0, el:(i >= 21), ep:1'b0, ec:0};
    for (int i = 22; i <= 24; i++)
      tbl[i] = '{r:1'b0, e:1'b0, b:1'b1, cl:1'b0, el:1'b1, ep:1'b0, ec:0};
    for (int i = 25; i <= 28; i++)
      tbl[i] = '{r:1'b0, e:1'b1, b:gen_next(), cl:1'b0, el:1'b1, ep:1'b0, ec:0};

    for (int i = 0; i < 29; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].b, tbl[i].cl);
      check("tbl_locked", {31'd0, if0.locked},    {31'd0, tbl[i].el});
      check("tbl_pulse",  {31'd0, if0.err_pulse}, {31'd0, tbl[i].ep});
      check("tbl_count",  {16'd0, if0.err_count}, tbl[i].ec);
    end

    // ---- isolated bit error while locked
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, gen_next(), 1'b0);
    step(1'b0, 1'b1, ~gen_next(), 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, gen_next(), 1'b0);
    check("iso_count",  {16'd0, if0.err_count}, ISO_CNT);
    check("iso_locked", {31'd0, if0.locked}, 32'd1);

    // ---- mid-operation reset with en and clr_count active
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_locked", {31'd0, if0.locked}, 32'd0);
    check("rst_count",  {16'd0, if0.err_count}, 32'd0);

    // ---- lock, then permanently inverted stream
    gs = 7'b0000001;
    for (int i = 0; i < 21; i++) step(1'b0, 1'b1, gen_next(), 1'b0);
    check("inv_prelock", {31'd0, if0.locked}, 32'd1);
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b1, ~gen_next(), 1'b0);
      if (i == UNL_BIT - 1) check("inv_still_locked", {31'd0, if0.locked}, 32'd1);
      if (i == UNL_BIT) begin
        check("inv_unlock",       {31'd0, if0.locked}, 32'd0);
        check("inv_unlock_count", {16'd0, if0.err_count}, UNL_CNT);
      end
    end
    check("sat_count",  {28'd0, if1.err_count}, 32'd15);
    check("sat_locked", {31'd0, if1.locked}, 32'd1);
    // clr_count on a mismatching bit: clear wins, pulse still fires
    step(1'b0, 1'b1, ~gen_next(), 1'b1);
    check("clr_count", {28'd0, if1.err_count}, 32'd0);
    check("clr_pulse", {31'd0, if1.err_pulse}, 32'd1);
    check("clr_keeps_lock", {31'd0, if1.locked}, 32'd1);
    // The complement of the sequence never satisfies the recurrence, so it
    // keeps ch0 unlocked; the true stream then relocks after 21 bits.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, ~gen_next(), 1'b0);
    check("inv_no_relock", {31'd0, if0.locked}, 32'd0);
    for (int i = 1; i <= 21; i++) begin
      step(1'b0, 1'b1, gen_next(), 1'b0);
      if (i == 20) check("relock_b20", {31'd0, if0.locked}, 32'd0);
      if (i == 21) check("relock_b21", {31'd0, if0.locked}, 32'd1);
    end

    // ---- stuck-0 line, then clean stream
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("zero_locked", {31'd0, if0.locked}, 32'd0);
    check("zero_count",  {16'd0, if0.err_count}, 32'd0);
    gs = 7'b0000001;
    for (int i = 1; i <= 21; i++) begin
      step(1'b0, 1'b1, gen_next(), 1'b0);
      if (i == 20) check("zero_relock_b20", {31'd0, if0.locked}, 32'd0);
      if (i == 21) check("zero_relock_b21", {31'd0, if0.locked}, 32'd1);
    end

    // ---- random enable, junk on bit_in while en=0
    step(1'b1, 1'b0, 1'b0, 1'b0);
    gs = 7'b0000001;
    en_cnt  = 0;
    lock_at = -1;
    for (int cyc = 0; cyc < 400 && lock_at < 0; cyc++) begin
      if ($urandom_range(0, 1) == 1) begin
        en_cnt++;
        step(1'b0, 1'b1, gen_next(), 1'b0);
      end else begin
        b = 1'($urandom_range(0, 1));
        step(1'b0, 1'b0, b, ($urandom_range(0, 7) == 0));
      end
      if (if0.locked === 1'b1) lock_at = en_cnt;
    end
    check("rand_en_lock_bits", lock_at, 32'd21);
    for (int i = 0; i < 40; i++) begin
      b = 1'($urandom_range(0, 1));
      step(1'b0, 1'($urandom_range(0, 1)), b, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
